rv32_d_alu_decode_stage: RTL and testbench

Registered, parametrised ALU-control decode stage for the RV32IMAFB_Zicsr decode path. It accepts an `alu_op` class from the main decoder plus the raw instruction, resolves the ALU operation and legality for the enabled extensions, and presents the result one cycle later. It has a valid/ready handshake, a skid buffer for full-throughput backpressure, and a flush. It sits between the main decoder and the ID/EX register, and its illegal flag and instruction word feed the CSR trap logic (mtval).

---
 rtl/rv32_pkg.sv | 33 +++
 rtl/rv32_d_alu_decode_stage_if.sv | 27 ++
 rtl/rv32_d_alu_decode_lut.sv | 141 ++++++++++++++
 rtl/rv32_d_alu_decode_stage.sv | 91 +++++++++
 tb/tb_rv32_d_alu_decode_stage.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 decode types: ALU operation encoding, alu_op classes and the ALU-decode record.
// Pure declarations; no logic and no timing.
package rv32_pkg;

  localparam int ALU_CONTROL_WIDTH = 6;

  typedef enum logic [ALU_CONTROL_WIDTH-1:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASS,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_SH1ADD, ALU_SH2ADD, ALU_SH3ADD,
    ALU_ANDN, ALU_ORN, ALU_XNOR, ALU_CLZ, ALU_CTZ, ALU_CPOP, ALU_MAX, ALU_MAXU,
    ALU_MIN, ALU_MINU, ALU_SEXTB, ALU_SEXTH, ALU_ZEXTH, ALU_ROL, ALU_ROR,
    ALU_ORCB, ALU_REV8,
    ALU_CLMUL, ALU_CLMULH, ALU_CLMULR,
    ALU_BCLR, ALU_BEXT, ALU_BINV, ALU_BSET
  } alu_op_e;

  localparam logic [2:0] ALUOP_ADD    = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_OP     = 3'b010;
  localparam logic [2:0] ALUOP_UPPER  = 3'b011;
  localparam logic [2:0] ALUOP_NONE   = 3'b100;

  typedef struct packed {
    alu_op_e     alu_control;
    logic        illegal;
    logic [31:0] instr;
  } alu_dec_t;

  localparam alu_dec_t ALU_DEC_RESET = '{alu_control: ALU_ADD, illegal: 1'b0, instr: 32'h0};

endpackage

// File: rtl/rv32_d_alu_decode_stage_if.sv
// Upstream/downstream handshake and payload of the ALU decode stage.
// slave = the stage itself, master = whoever drives it.
interface rv32_d_alu_decode_stage_if;
  import rv32_pkg::*;

  logic                         flush_i;
  logic                         valid_i;
  logic                         ready_o;
  logic [2:0]                   alu_op_i;
  logic [31:0]                  instr_i;
  logic                         valid_o;
  logic                         ready_i;
  logic [ALU_CONTROL_WIDTH-1:0] alu_control_o;
  logic                         illegal_o;
  logic [31:0]                  instr_o;

  modport slave (
    input  flush_i, valid_i, alu_op_i, instr_i, ready_i,
    output ready_o, valid_o, alu_control_o, illegal_o, instr_o
  );

  modport master (
    output flush_i, valid_i, alu_op_i, instr_i, ready_i,
    input  ready_o, valid_o, alu_control_o, illegal_o, instr_o
  );

endinterface

// File: rtl/rv32_d_alu_decode_lut.sv
// Combinational ALU-control lookup: alu_op class + instruction -> {alu_control, illegal, instr}.
// Zero latency, no state; illegal encodings resolve to ALU_ADD with illegal set.
module rv32_d_alu_decode_lut
  import rv32_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_B = 1'b1
) (
  input  logic [2:0]  alu_op_i,
  input  logic [31:0] instr_i,
  output alu_dec_t    dec_o
);

  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs2;
  logic       is_reg;
  alu_op_e    op;
  logic       ok;
  logic       m_op;
  logic       b_op;

  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rs2    = instr_i[24:20];
  assign is_reg = instr_i[5];

  always_comb begin
    op   = ALU_ADD;
    ok   = 1'b1;
    m_op = 1'b0;
    b_op = 1'b0;
    case (alu_op_i)
      ALUOP_ADD, ALUOP_NONE: op = ALU_ADD;
      ALUOP_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: op = ALU_XOR;
          3'b100, 3'b101: op = ALU_SLT;
          3'b110, 3'b111: op = ALU_SLTU;
          default:        ok = 1'b0;
        endcase
      end
      ALUOP_UPPER: op = is_reg ? ALU_PASS : ALU_ADD;
      ALUOP_OP: begin
        if (!is_reg && funct3 != 3'b001 && funct3 != 3'b101) begin
          case (funct3)
            3'b000:  op = ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
          endcase
        end else if (!is_reg) begin
          // Shift-immediates: funct7 must match exactly, so shamt[5]=1 falls to default.
          case ({funct7, funct3})
            {7'b0000000, 3'b001}: op = ALU_SLL;
            {7'b0000000, 3'b101}: op = ALU_SRL;
            {7'b0100000, 3'b101}: op = ALU_SRA;
            {7'b0110000, 3'b001}: begin
              b_op = 1'b1;
              case (rs2)
                5'b00000: op = ALU_CLZ;
                5'b00001: op = ALU_CTZ;
                5'b00010: op = ALU_CPOP;
                5'b00100: op = ALU_SEXTB;
                5'b00101: op = ALU_SEXTH;
                default:  ok = 1'b0;
              endcase
            end
            {7'b0010100, 3'b001}: begin b_op = 1'b1; op = ALU_BSET; end
            {7'b0100100, 3'b001}: begin b_op = 1'b1; op = ALU_BCLR; end
            {7'b0110100, 3'b001}: begin b_op = 1'b1; op = ALU_BINV; end
            {7'b0100100, 3'b101}: begin b_op = 1'b1; op = ALU_BEXT; end
            {7'b0110000, 3'b101}: begin b_op = 1'b1; op = ALU_ROR;  end
            {7'b0010100, 3'b101}: begin b_op = 1'b1; op = ALU_ORCB; ok = (rs2 == 5'b00111); end
            {7'b0110100, 3'b101}: begin b_op = 1'b1; op = ALU_REV8; ok = (rs2 == 5'b11000); end
            default: ok = 1'b0;
          endcase
        end else if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0000001) begin
          m_op = 1'b1;
          case (funct3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
          endcase
        end else begin
          b_op = 1'b1;
          case ({funct7, funct3})
            {7'b0100000, 3'b000}: begin b_op = 1'b0; op = ALU_SUB; end
            {7'b0100000, 3'b101}: begin b_op = 1'b0; op = ALU_SRA; end
            {7'b0100000, 3'b111}: op = ALU_ANDN;
            {7'b0100000, 3'b110}: op = ALU_ORN;
            {7'b0100000, 3'b100}: op = ALU_XNOR;
            {7'b0010000, 3'b010}: op = ALU_SH1ADD;
            {7'b0010000, 3'b100}: op = ALU_SH2ADD;
            {7'b0010000, 3'b110}: op = ALU_SH3ADD;
            {7'b0000101, 3'b001}: op = ALU_CLMUL;
            {7'b0000101, 3'b011}: op = ALU_CLMULH;
            {7'b0000101, 3'b010}: op = ALU_CLMULR;
            {7'b0000101, 3'b100}: op = ALU_MIN;
            {7'b0000101, 3'b101}: op = ALU_MINU;
            {7'b0000101, 3'b110}: op = ALU_MAX;
            {7'b0000101, 3'b111}: op = ALU_MAXU;
            {7'b0110000, 3'b001}: op = ALU_ROL;
            {7'b0110000, 3'b101}: op = ALU_ROR;
            {7'b0000100, 3'b100}: begin op = ALU_ZEXTH; ok = (rs2 == 5'b00000); end
            {7'b0100100, 3'b001}: op = ALU_BCLR;
            {7'b0100100, 3'b101}: op = ALU_BEXT;
            {7'b0010100, 3'b001}: op = ALU_BSET;
            {7'b0110100, 3'b001}: op = ALU_BINV;
            default: ok = 1'b0;
          endcase
        end
      end
      default: ok = 1'b0;
    endcase
    if (m_op && !ENABLE_M) ok = 1'b0;
    if (b_op && !ENABLE_B) ok = 1'b0;
    dec_o.alu_control = ok ? op : ALU_ADD;
    dec_o.illegal     = ~ok;
    dec_o.instr       = instr_i;
  end

endmodule

// File: rtl/rv32_d_alu_decode_stage.sv
// Registered ALU-control decode stage: 1-cycle latency, full throughput, valid/ready with
// optional skid entry so ready_o comes straight from a flop; flush drops everything held.
module rv32_d_alu_decode_stage
  import rv32_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_B = 1'b1,
  parameter bit SKID     = 1'b1
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  rv32_d_alu_decode_stage_if.slave bus
);

  alu_dec_t dec;
  alu_dec_t out_q, out_d, skid_q, skid_d;
  logic     out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic     ready;
  logic     accept;

  rv32_d_alu_decode_lut #(.ENABLE_M(ENABLE_M), .ENABLE_B(ENABLE_B)) u_lut (
    .alu_op_i (bus.alu_op_i),
    .instr_i  (bus.instr_i),
    .dec_o    (dec)
  );

  assign accept = bus.valid_i & ready & ~bus.flush_i;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (bus.flush_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // Skid only ever holds data behind a valid output, so draining keeps out_vld set.
      if (bus.ready_i) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_vld_q || bus.ready_i) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end
    end else if (bus.ready_i) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_vld_q <= 1'b0;
      out_q     <= ALU_DEC_RESET;
    end else begin
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          skid_vld_q <= 1'b0;
          skid_q     <= ALU_DEC_RESET;
        end else begin
          skid_vld_q <= skid_vld_d;
          skid_q     <= skid_d;
        end
      end
      assign ready = ~skid_vld_q;
    end else begin : g_no_skid
      assign skid_vld_q = 1'b0;
      assign skid_q     = ALU_DEC_RESET;
      assign ready      = ~out_vld_q | bus.ready_i;
    end
  endgenerate

  assign bus.ready_o       = ready;
  assign bus.valid_o       = out_vld_q;
  assign bus.alu_control_o = out_q.alu_control;
  assign bus.illegal_o     = out_q.illegal;
  assign bus.instr_o       = out_q.instr;

endmodule

// File: tb/tb_rv32_d_alu_decode_stage.sv
// Bench for rv32_d_alu_decode_stage: full-feature and M/B-disabled instances share one stream;
// a scoreboard queue follows accepted entries to the output, plus stall/flush/reset sequences.
module tb_rv32_d_alu_decode_stage;
  import rv32_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] instr;
    alu_op_e     alu_f;
    logic        ill_f;
    alu_op_e     alu_m;
    logic        ill_m;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t drv;
  vec_t sb[$];
  vec_t vt[$];

  always #5 clk = ~clk;

  rv32_d_alu_decode_stage_if bus ();
  rv32_d_alu_decode_stage_if bus2 ();

  assign bus2.flush_i  = bus.flush_i;
  assign bus2.valid_i  = bus.valid_i;
  assign bus2.alu_op_i = bus.alu_op_i;
  assign bus2.instr_i  = bus.instr_i;
  assign bus2.ready_i  = bus.ready_i;

  rv32_d_alu_decode_stage #(.ENABLE_M(1'b1), .ENABLE_B(1'b1), .SKID(1'b1)) dut (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus)
  );
  rv32_d_alu_decode_stage #(.ENABLE_M(1'b0), .ENABLE_B(1'b0), .SKID(1'b1)) dut_min (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] ins, input alu_op_e af,
                              input logic illf, input alu_op_e am, input logic illm);
    vec_t v;
    v.op = op; v.instr = ins; v.alu_f = af; v.ill_f = illf; v.alu_m = am; v.ill_m = illm;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    drv          = v;
    bus.valid_i  = 1'b1;
    bus.alu_op_i = v.op;
    bus.instr_i  = v.instr;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on output transfer, push on input transfer, both judged mid-cycle.
  always @(negedge clk) begin
    if (!rst_n || bus.flush_i) begin
      sb.delete();
    end else begin
      if (bus.valid_o && bus.ready_i) begin
        if (sb.size() == 0) begin
          chk("spurious_out", bus.instr_o, 32'hxxxxxxxx);
        end else begin
          vec_t e;
          e = sb.pop_front();
          chk("instr_o", bus.instr_o, e.instr);
          chk("alu_full", {26'd0, bus.alu_control_o}, {26'd0, e.alu_f});
          chk("ill_full", {31'd0, bus.illegal_o}, {31'd0, e.ill_f});
          chk("alu_min", {26'd0, bus2.alu_control_o}, {26'd0, e.alu_m});
          chk("ill_min", {31'd0, bus2.illegal_o}, {31'd0, e.ill_m});
        end
      end
      if (bus.valid_i && bus.ready_o) sb.push_back(drv);
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_valid_o"}, {31'd0, bus.valid_o}, 32'd0);
    chk({tag, "_illegal_o"}, {31'd0, bus.illegal_o}, 32'd0);
    chk({tag, "_alu"}, {26'd0, bus.alu_control_o}, {26'd0, ALU_ADD});
    chk({tag, "_instr_o"}, bus.instr_o, 32'd0);
    chk({tag, "_ready_o"}, {31'd0, bus.ready_o}, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_left"}, sb.size(), 32'd0);
  endtask

  vec_t a, b, c, d;

  initial begin
    bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.alu_op_i = 3'b0; bus.instr_i = 32'h0;
    bus.ready_i = 1'b1;
    drv = mk(3'b0, 32'h0, ALU_ADD, 1'b0, ALU_ADD, 1'b0);

    vt.push_back(mk(ALUOP_OP,     32'h003100B3, ALU_ADD,   1'b0, ALU_ADD,  1'b0));
    vt.push_back(mk(ALUOP_OP,     32'h023100B3, ALU_MUL,   1'b0, ALU_ADD,  1'b1));
    vt.push_back(mk(ALUOP_OP,     32'h40310133, ALU_SUB,   1'b0, ALU_SUB,  1'b0));
    vt.push_back(mk(ALUOP_BRANCH, 32'h00002063, ALU_ADD,   1'b1, ALU_ADD,  1'b1));
    vt.push_back(mk(ALUOP_BRANCH, 32'h00000063, ALU_XOR,   1'b0, ALU_XOR,  1'b0));
    vt.push_back(mk(ALUOP_BRANCH, 32'h00006063, ALU_SLTU,  1'b0, ALU_SLTU, 1'b0));
    vt.push_back(mk(ALUOP_BRANCH, 32'h00005063, ALU_SLT,   1'b0, ALU_SLT,  1'b0));
    vt.push_back(mk(ALUOP_OP,     32'h60009093, ALU_CLZ,   1'b0, ALU_ADD,  1'b1));
    vt.push_back(mk(ALUOP_OP,     32'h02009093, ALU_ADD,   1'b1, ALU_ADD,  1'b1));
    vt.push_back(mk(ALUOP_OP,     32'h00309093, ALU_SLL,   1'b0, ALU_SLL,  1'b0));
    vt.push_back(mk(ALUOP_OP,     32'h4050D093, ALU_SRA,   1'b0, ALU_SRA,  1'b0));
    vt.push_back(mk(ALUOP_UPPER,  32'h000010B7, ALU_PASS,  1'b0, ALU_PASS, 1'b0));
    vt.push_back(mk(ALUOP_UPPER,  32'h00001097, ALU_ADD,   1'b0, ALU_ADD,  1'b0));
    vt.push_back(mk(ALUOP_NONE,   32'h00002003, ALU_ADD,   1'b0, ALU_ADD,  1'b0));
    vt.push_back(mk(3'b101,       32'h003100B3, ALU_ADD,   1'b1, ALU_ADD,  1'b1));
    vt.push_back(mk(3'b111,       32'h003100B3, ALU_ADD,   1'b1, ALU_ADD,  1'b1));
    vt.push_back(mk(ALUOP_OP,     32'h403170B3, ALU_ANDN,  1'b0, ALU_ADD,  1'b1));
    vt.push_back(mk(ALUOP_OP,     32'h023150B3, ALU_DIVU,  1'b0, ALU_ADD,  1'b1));
    vt.push_back(mk(ALUOP_OP,     32'hFFF0C093, ALU_XOR,   1'b0, ALU_XOR,  1'b0));
    vt.push_back(mk(ALUOP_OP,     32'h6980D093, ALU_REV8,  1'b0, ALU_ADD,  1'b1));

    // Reset values
    edge1(); edge1();
    @(negedge clk);
    chk_reset("rst0");
    edge1();
    rst_n = 1'b1;

    // First transfer: one cycle latency
    drive(vt[0]);
    @(negedge clk);
    chk("lat_ready_o", {31'd0, bus.ready_o}, 32'd1);
    edge1();
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("lat_valid_o", {31'd0, bus.valid_o}, 32'd1);
    chk("lat_instr_o", bus.instr_o, 32'h003100B3);

    // Back-to-back table stream
    for (int i = 1; i < vt.size(); i++) begin
      edge1();
      drive(vt[i]);
    end
    edge1();
    bus.valid_i = 1'b0;
    drain("table");

    // Stall: A held, B to skid, C blocked; then release
    a = mk(ALUOP_OP, 32'h003100B3, ALU_ADD, 1'b0, ALU_ADD, 1'b0);
    b = mk(ALUOP_OP, 32'h023100B3, ALU_MUL, 1'b0, ALU_ADD, 1'b1);
    c = mk(ALUOP_OP, 32'h60009093, ALU_CLZ, 1'b0, ALU_ADD, 1'b1);
    d = mk(ALUOP_OP, 32'h40310133, ALU_SUB, 1'b0, ALU_SUB, 1'b0);
    edge1(); drive(a); bus.ready_i = 1'b1;
    edge1(); drive(b); bus.ready_i = 1'b0;
    edge1(); drive(c);
    @(negedge clk);
    chk("stall_ready_o", {31'd0, bus.ready_o}, 32'd0);
    chk("stall_valid_o", {31'd0, bus.valid_o}, 32'd1);
    chk("stall_hold1", bus.instr_o, a.instr);
    edge1();
    @(negedge clk);
    chk("stall_hold2", bus.instr_o, a.instr);
    chk("stall_ready2", {31'd0, bus.ready_o}, 32'd0);
    edge1(); bus.ready_i = 1'b1;
    @(negedge clk);
    chk("rel_v0", {31'd0, bus.valid_o}, 32'd1);
    edge1();
    @(negedge clk);
    chk("rel_v1", {31'd0, bus.valid_o}, 32'd1);
    chk("rel_ready_back", {31'd0, bus.ready_o}, 32'd1);
    edge1(); bus.valid_i = 1'b0;
    @(negedge clk);
    chk("rel_v2", {31'd0, bus.valid_o}, 32'd1);
    chk("rel_last", bus.instr_o, c.instr);
    edge1();
    @(negedge clk);
    chk("rel_empty", {31'd0, bus.valid_o}, 32'd0);
    chk("rel_sb", sb.size(), 32'd0);

    // Flush with both entries full, then flush discarding an acceptable input
    edge1(); drive(a); bus.ready_i = 1'b0;
    edge1(); drive(b);
    edge1(); drive(c);
    @(negedge clk);
    chk("fl_full_ready", {31'd0, bus.ready_o}, 32'd0);
    bus.flush_i = 1'b1;
    edge1(); drive(d);
    @(negedge clk);
    chk("fl_valid_o", {31'd0, bus.valid_o}, 32'd0);
    chk("fl_ready_o", {31'd0, bus.ready_o}, 32'd1);
    edge1(); bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_discard", {31'd0, bus.valid_o}, 32'd0);
      edge1();
    end

    // Reset mid-stall, then an immediate transfer
    drive(a); bus.ready_i = 1'b0;
    edge1(); drive(b);
    edge1(); bus.valid_i = 1'b0;
    @(negedge clk);
    chk("rs_stalled", {31'd0, bus.ready_o}, 32'd0);
    edge1(); rst_n = 1'b0;
    edge1(); rst_n = 1'b1; drive(d); bus.ready_i = 1'b1;
    @(negedge clk);
    chk_reset("rst_mid");
    edge1(); bus.valid_i = 1'b0;
    @(negedge clk);
    chk("rs_after_valid", {31'd0, bus.valid_o}, 32'd1);
    chk("rs_after_instr", bus.instr_o, d.instr);
    drain("reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
